// File: rtl/frame_drawer.sv
// frame_drawer: on a one-cycle start request, paints one animation frame as a
// stream of VGA pixel writes. It erases the old ball, draws the new ball and the
// four platforms, then emits a one-cycle done pulse. Every data input is
// captured when the frame starts, so changes to the inputs mid-frame have no
// effect on the frame in progress.
// Optional build macro SCORE_BAR_EN adds a score bar pass on row 0 after the
// platforms. It is white up to min(score,160) columns and black for the rest.
// In the default build the score_out input is left unconnected internally.
//
// state   | meaning
// IDLE    | waiting for start, all outputs low
// ERASE   | paint previous ball square black
// BALL    | paint current ball square in ball colour
// PLAT0-3 | paint platform i, PLAT_W x 2 pixels
// BAR     | score bar on row 0 (SCORE_BAR_EN only)
// DONE    | one-cycle done pulse
module frame_drawer #(
    parameter int BALL_X    = 76,
    parameter int BALL_SIZE = 4,
    parameter int PLAT_W    = 16,
    parameter int PLAT_Y    = 112
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  prev_ball_out,
    input  logic [7:0]  curr_ball_out,
    input  logic [2:0]  color_ball_out,
    input  logic [11:0] color_plats_out,
    input  logic [31:0] position_plats_out,
    input  logic [15:0] score_out,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE, S_ERASE, S_BALL, S_PLAT0, S_PLAT1, S_PLAT2, S_PLAT3, S_BAR, S_DONE
    } state_t;

    localparam logic [8:0] BALL_X9   = 9'(BALL_X);
    localparam logic [8:0] PLAT_Y9   = 9'(PLAT_Y);
    localparam logic [7:0] BALL_LAST = 8'(BALL_SIZE - 1);
    localparam logic [7:0] PLAT_LAST = 8'(PLAT_W - 1);

    state_t      state_q, state_d, after;
    logic [7:0]  col_q, col_d, row_q, row_d;
    logic [7:0]  prev_q, curr_q;
    logic [2:0]  ball_col_q;
    logic [11:0] pcol_q;
    logic [31:0] pos_q;
    logic        load;
    logic        pix_en;
    logic [8:0]  base_x, base_y, x_sum, y_sum;
    logic [2:0]  pix_col;
    logic [7:0]  last_col, last_row;
`ifdef SCORE_BAR_EN
    logic [15:0] score_q;
`endif

    assign load = (state_q == S_IDLE) && start;

    // State, scan counters and frame shadow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            prev_q     <= '0;
            curr_q     <= '0;
            ball_col_q <= '0;
            pcol_q     <= '0;
            pos_q      <= '0;
`ifdef SCORE_BAR_EN
            score_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (load) begin
                prev_q     <= prev_ball_out;
                curr_q     <= curr_ball_out;
                ball_col_q <= color_ball_out;
                pcol_q     <= color_plats_out;
                pos_q      <= position_plats_out;
`ifdef SCORE_BAR_EN
                score_q    <= score_out;
`endif
            end
        end
    end

    // Per-state scan geometry, pixel address and next-state sequencing
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        pix_en   = 1'b0;
        base_x   = '0;
        base_y   = '0;
        pix_col  = '0;
        last_col = '0;
        last_row = '0;
        after    = S_IDLE;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ERASE;
            S_ERASE: begin
                pix_en = 1'b1; base_x = BALL_X9; base_y = {1'b0, prev_q};
                last_col = BALL_LAST; last_row = BALL_LAST; after = S_BALL;
            end
            S_BALL: begin
                pix_en = 1'b1; base_x = BALL_X9; base_y = {1'b0, curr_q};
                pix_col = ball_col_q;
                last_col = BALL_LAST; last_row = BALL_LAST; after = S_PLAT0;
            end
            S_PLAT0: begin
                pix_en = 1'b1; base_x = {1'b0, pos_q[7:0]}; pix_col = pcol_q[2:0];
                after = S_PLAT1;
            end
            S_PLAT1: begin
                pix_en = 1'b1; base_x = {1'b0, pos_q[15:8]}; pix_col = pcol_q[5:3];
                after = S_PLAT2;
            end
            S_PLAT2: begin
                pix_en = 1'b1; base_x = {1'b0, pos_q[23:16]}; pix_col = pcol_q[8:6];
                after = S_PLAT3;
            end
            S_PLAT3: begin
                pix_en = 1'b1; base_x = {1'b0, pos_q[31:24]}; pix_col = pcol_q[11:9];
`ifdef SCORE_BAR_EN
                after = S_BAR;
`else
                after = S_DONE;
`endif
            end
`ifdef SCORE_BAR_EN
            S_BAR: begin
                pix_en   = 1'b1;
                last_col = 8'd159;
                pix_col  = ({8'd0, col_q} < score_q) ? 3'b111 : 3'b000;
                after    = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Platforms share one geometry; only base column and colour differ
        if (state_q == S_PLAT0 || state_q == S_PLAT1 ||
            state_q == S_PLAT2 || state_q == S_PLAT3) begin
            base_y   = PLAT_Y9;
            last_col = PLAT_LAST;
            last_row = 8'd1;
        end

        // 9-bit sums so a shape hanging past the screen edge never wraps back on
        x_sum = base_x + {1'b0, col_q};
        y_sum = base_y + {1'b0, row_q};

        if (pix_en) begin
            if (col_q == last_col) begin
                col_d = '0;
                if (row_q == last_row) begin
                    row_d   = '0;
                    state_d = after;
                end else begin
                    row_d = row_q + 8'd1;
                end
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    // VGA write port and status; off-screen pixels still take their cycle
    always_comb begin
        plot   = pix_en && (x_sum < 9'd160) && (y_sum < 9'd120);
        x      = pix_en ? x_sum[7:0] : 8'd0;
        y      = pix_en ? y_sum[6:0] : 7'd0;
        colour = pix_en ? pix_col : 3'd0;
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_frame_drawer.sv
`timescale 1ns/1ps
module tb_frame_drawer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  prev_ball, curr_ball;
    logic [2:0]  ball_col;
    logic [11:0] plat_col;
    logic [31:0] plat_pos;
    logic [15:0] score;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       pl;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    px_t exp_q[$];

    always #5 clk = ~clk;

    frame_drawer dut (
        .clk(clk), .reset(reset), .start(start),
        .prev_ball_out(prev_ball), .curr_ball_out(curr_ball),
        .color_ball_out(ball_col), .color_plats_out(plat_col),
        .position_plats_out(plat_pos), .score_out(score),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_px(input int px, input int py, input logic [2:0] c);
        px_t p;
        p.pl = (px < 160) && (py < 120);
        p.x  = px[7:0];
        p.y  = py[6:0];
        p.c  = c;
        exp_q.push_back(p);
    endtask

    // Expected pixel stream for one frame, from the current input values
    task automatic build_model();
        int pos, lim, p8;
        logic [2:0] pc;
        exp_q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) add_px(76 + c, int'(prev_ball) + r, 3'b000);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) add_px(76 + c, int'(curr_ball) + r, ball_col);
        for (int i = 0; i < 4; i++) begin
            p8  = int'(plat_pos >> (8 * i));
            pos = p8 & 255;
            pc  = 3'((plat_col >> (3 * i)) & 12'h7);
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 16; c++) add_px(pos + c, 112 + r, pc);
        end
`ifdef SCORE_BAR_EN
        lim = (int'(score) < 160) ? int'(score) : 160;
        for (int c = 0; c < 160; c++) add_px(c, 0, (c < lim) ? 3'b111 : 3'b000);
`else
        lim = 0;
`endif
    endtask

    task automatic rand_inputs();
        prev_ball = 8'($urandom_range(0, 255));
        curr_ball = 8'($urandom_range(0, 255));
        ball_col  = 3'($urandom);
        plat_col  = 12'($urandom);
        plat_pos  = $urandom;
        score     = 16'($urandom_range(0, 300));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_plot"},   32'(plot),   32'd0);
        check_eq({tag, "_busy"},   32'(busy),   32'd0);
        check_eq({tag, "_done"},   32'(done),   32'd0);
        check_eq({tag, "_x"},      32'(x),      32'd0);
        check_eq({tag, "_y"},      32'(y),      32'd0);
        check_eq({tag, "_colour"}, 32'(colour), 32'd0);
    endtask

    // One frame: pulse start, compare every pixel cycle, then done and busy drop.
    // disturb_cyc re-pulses start and scrambles inputs; reset_cyc aborts via reset.
    task automatic run_frame(input int disturb_cyc, input int reset_cyc);
        int n;
        px_t e;
        build_model();
        n = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= n; cyc++) begin
            if (cyc == reset_cyc) begin
                #2;
                reset = 1'b1;
                #1;
                check_idle_outputs("rst_mid");
                start = 1'b1;
                @(posedge clk);
                #1;
                check_eq("rst_start_ignored", 32'(busy), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            if (cyc == disturb_cyc) begin
                start = 1'b1;
                rand_inputs();
            end
            e = exp_q[cyc - 1];
            check_eq($sformatf("plot@%0d", cyc), 32'(plot), 32'(e.pl));
            if (e.pl) begin
                check_eq($sformatf("x@%0d", cyc),      32'(x),      32'(e.x));
                check_eq($sformatf("y@%0d", cyc),      32'(y),      32'(e.y));
                check_eq($sformatf("colour@%0d", cyc), 32'(colour), 32'(e.c));
            end
            check_eq($sformatf("busy@%0d", cyc), 32'(busy), 32'd1);
            check_eq($sformatf("done@%0d", cyc), 32'(done), 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_plot",  32'(plot), 32'd0);
        check_eq("done_busy",  32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check_eq("after_busy", 32'(busy), 32'd0);
        check_eq("after_done", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        prev_ball = '0; curr_ball = '0; ball_col = '0;
        plat_col = '0; plat_pos = '0; score = '0;
        #22;
        check_idle_outputs("reset");
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;

        // Reference frame
        prev_ball = 8'd40; curr_ball = 8'd44; ball_col = 3'b101;
        plat_pos = 32'h5F73879B; plat_col = 12'h3BD; score = 16'd200;
        run_frame(0, 0);

        // Ball partly below the screen
        curr_ball = 8'd118;
        run_frame(0, 0);

        // Platform straddling the right edge
        plat_pos = 32'h5F7396_9B;
        run_frame(0, 0);

        // Restart attempt and input changes mid-frame
        prev_ball = 8'd10; curr_ball = 8'd20; score = 16'd10;
        run_frame(50, 0);

        // Reset mid-frame, then a complete frame
        run_frame(0, 80);
        prev_ball = 8'd40; curr_ball = 8'd44; ball_col = 3'b101;
        plat_pos = 32'h5F73879B; plat_col = 12'h3BD; score = 16'd10;
        run_frame(0, 0);

        // Back-to-back randomized frames
        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            run_frame(0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
